// File: rtl/external_io_host_if.sv
// rtl/external_io_host_if.sv - command/response bundle between the front end and external_io_host
interface external_io_host_if #(
    parameter int JOB_CONFIG_WIDTH    = 1,
    parameter int DEVICE_CONFIG_WIDTH = 1,
    parameter int RESULT_DATA_WIDTH   = 1
);
    localparam int RX_W = (DEVICE_CONFIG_WIDTH > RESULT_DATA_WIDTH) ? DEVICE_CONFIG_WIDTH
                                                                    : RESULT_DATA_WIDTH;

    logic                           start;
    logic [1:0]                     op;
    logic [JOB_CONFIG_WIDTH-1:0]    job_config;
    logic [DEVICE_CONFIG_WIDTH-1:0] device_config;
    logic [RX_W-1:0]                rx_data;
    logic                           busy;
    logic                           done;

    modport master (
        output start, op, job_config, device_config,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, op, job_config, device_config,
        output rx_data, busy, done
    );
endinterface

// File: rtl/external_io_host.sv
// rtl/external_io_host.sv - two-channel SPI initiator that configures, runs and reads back a shapool device
// Optional automatic result read after RUN: EXTERNAL_IO_HOST_AUTOREAD_EN
module external_io_host #(
    parameter int JOB_CONFIG_WIDTH    = 1,
    parameter int DEVICE_CONFIG_WIDTH = 1,
    parameter int RESULT_DATA_WIDTH   = 1,
    parameter int SCK_HALF            = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    external_io_host_if.slave cmd,
    output logic              dev_reset_n,
    output logic              sck0,
    output logic              sdi0,
    output logic              cs0_n,
    output logic              sck1,
    output logic              sdi1,
    output logic              cs1_n,
    input  logic              sdo1,
    input  logic              ready
);
    localparam int RX_W  = (DEVICE_CONFIG_WIDTH > RESULT_DATA_WIDTH) ? DEVICE_CONFIG_WIDTH
                                                                     : RESULT_DATA_WIDTH;
    localparam int TX_W  = (JOB_CONFIG_WIDTH > DEVICE_CONFIG_WIDTH) ? JOB_CONFIG_WIDTH
                                                                    : DEVICE_CONFIG_WIDTH;
    localparam int MAX_W = (TX_W > RESULT_DATA_WIDTH) ? TX_W : RESULT_DATA_WIDTH;
    localparam int BIT_W = $clog2(MAX_W + 1);
    localparam int PH_W  = $clog2(SCK_HALF + 1);

    localparam logic [1:0] OP_LOAD_JOB    = 2'b00;
    localparam logic [1:0] OP_LOAD_DEVICE = 2'b01;
    localparam logic [1:0] OP_READ_RESULT = 2'b10;
    localparam logic [1:0] OP_RUN         = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SHIFT_LOW, SHIFT_HIGH, HOLD, FINISH, WAIT_READY
    } state_t;

    state_t            state, state_n;
    logic [1:0]        cmd_op;
    logic [TX_W-1:0]   tx_shift;
    logic [RX_W-1:0]   rx_shift;
    logic [RX_W-1:0]   rx_data_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  last_bit;
    logic [PH_W-1:0]   phase;
    logic              dev_reset_q;
    logic              ready_go;

    wire phase_last = (phase == PH_W'(SCK_HALF - 1));
    wire bit_last   = (bit_cnt == last_bit);
    wire shifting   = (state == SHIFT_LOW) || (state == SHIFT_HIGH);
    wire in_xfer    = shifting || (state == HOLD);
    wire on_ch1     = (cmd_op == OP_LOAD_DEVICE) || (cmd_op == OP_READ_RESULT);

`ifdef EXTERNAL_IO_HOST_AUTOREAD_EN
    logic [1:0] ready_sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_sync <= 2'b00;
        else          ready_sync <= {ready_sync[0], ready};
    end
    assign ready_go = ready_sync[1];
    localparam state_t RUN_NEXT = WAIT_READY;
`else
    logic unused_ready;
    assign unused_ready = ready;
    assign ready_go     = 1'b0;
    localparam state_t RUN_NEXT = FINISH;
`endif

    always_comb begin
        last_bit = BIT_W'(RESULT_DATA_WIDTH - 1);
        case (cmd_op)
            OP_LOAD_JOB:    last_bit = BIT_W'(JOB_CONFIG_WIDTH - 1);
            OP_LOAD_DEVICE: last_bit = BIT_W'(DEVICE_CONFIG_WIDTH - 1);
            default:        last_bit = BIT_W'(RESULT_DATA_WIDTH - 1);
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (cmd.start) state_n = (cmd.op == OP_RUN) ? RUN_NEXT : SHIFT_LOW;
            SHIFT_LOW:  if (phase_last) state_n = SHIFT_HIGH;
            SHIFT_HIGH: if (phase_last) state_n = bit_last ? HOLD : SHIFT_LOW;
            HOLD:       if (phase_last) state_n = FINISH;
            FINISH:     state_n = IDLE;
            WAIT_READY: if (ready_go) state_n = SHIFT_LOW;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cmd_op      <= OP_LOAD_JOB;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data_q   <= '0;
            bit_cnt     <= '0;
            phase       <= '0;
            dev_reset_q <= 1'b0;
        end else begin
            state <= state_n;
            // Phase restarts on every state change so each half-period is exactly SCK_HALF long
            if (state_n != state || !in_xfer) phase <= '0;
            else                              phase <= phase + 1'b1;

            if (state == IDLE && cmd.start) begin
                cmd_op   <= cmd.op;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                case (cmd.op)
                    OP_LOAD_JOB: begin
                        tx_shift    <= TX_W'(cmd.job_config) << (TX_W - JOB_CONFIG_WIDTH);
                        dev_reset_q <= 1'b0;
                    end
                    OP_LOAD_DEVICE: begin
                        tx_shift    <= TX_W'(cmd.device_config) << (TX_W - DEVICE_CONFIG_WIDTH);
                        dev_reset_q <= 1'b0;
                    end
                    OP_RUN:  dev_reset_q <= 1'b1;
                    default: ;
                endcase
            end
            if (state == WAIT_READY && ready_go) begin
                cmd_op   <= OP_READ_RESULT;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
            end
            if (state == SHIFT_LOW && phase_last)
                rx_shift <= (rx_shift << 1) | RX_W'(sdo1);
            if (state == SHIFT_HIGH && phase_last && !bit_last) begin
                bit_cnt  <= bit_cnt + 1'b1;
                tx_shift <= tx_shift << 1;
            end
            if (state == HOLD && phase_last && cmd_op != OP_LOAD_JOB)
                rx_data_q <= rx_shift;
        end
    end

    assign sck0  = (state == SHIFT_HIGH) && !on_ch1;
    assign sck1  = (state == SHIFT_HIGH) && on_ch1;
    assign sdi0  = shifting && !on_ch1 && tx_shift[TX_W-1];
    assign sdi1  = shifting && on_ch1 && tx_shift[TX_W-1];
    assign cs0_n = !(in_xfer && !on_ch1);
    assign cs1_n = !(in_xfer && on_ch1);

    assign dev_reset_n = dev_reset_q;
    assign cmd.rx_data = rx_data_q;
    assign cmd.busy    = in_xfer || (state == WAIT_READY);
    assign cmd.done    = (state == FINISH);
endmodule

// File: doc/external_io_host.md
# external_io_host

Host-side SPI initiator for the two-channel configuration/result interface of a shapool device. Drives the device's `sck0/sdi0/cs0_n` (job channel) and `sck1/sdi1/cs1_n` (device channel) plus its core reset, and samples its `sdo1` and `ready`. It sits in the controller FPGA between a command front end and one shapool device. It serialises job and device configuration into the device, releases it to run, and reads back the result word.

## Interface
Parameters:
- `JOB_CONFIG_WIDTH`, 1: job word bits shifted on channel 0.
- `DEVICE_CONFIG_WIDTH`, 1: device word bits shifted on channel 1.
- `RESULT_DATA_WIDTH`, 1: result word bits read on channel 1.
- `SCK_HALF`, 4: SCK half-period in `clk` cycles; must be ≥4 to cover the device's 3-stage edge synchroniser.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe; accepted only when `busy`=0.
- `op` in 2: command. 00 LOAD_JOB, 01 LOAD_DEVICE, 10 READ_RESULT, 11 RUN.
- `job_config` in JOB_CONFIG_WIDTH: word for LOAD_JOB, sampled at accept.
- `device_config` in DEVICE_CONFIG_WIDTH: word for LOAD_DEVICE, sampled at accept.
- `rx_data` out RX_W = max(DEVICE_CONFIG_WIDTH, RESULT_DATA_WIDTH): captured bits, zero-extended; reset 0.
- `busy` out 1: transaction in progress; reset 0.
- `done` out 1: one-cycle completion pulse; reset 0.
- `dev_reset_n` out 1: drives device `reset_n`; reset 0.
- `sck0`, `sdi0`, `cs0_n` out 1 each: channel 0; reset 0, 0, 1.
- `sck1`, `sdi1`, `cs1_n` out 1 each: channel 1; reset 0, 0, 1.
- `sdo1` in 1: device channel-1 serial output.
- `ready` in 1: device result-ready flag.

## Operation
- States: IDLE, SHIFT_LOW, SHIFT_HIGH, HOLD, FINISH.
- On accept, the command is latched, `busy`=1, and the transmit word is loaded into a shift register (MSB first).
- LOAD_JOB:
  - `dev_reset_n`←0.
  - Shifts JOB_CONFIG_WIDTH bits on channel 0.
  - `rx_data` is unchanged.
- LOAD_DEVICE:
  - `dev_reset_n`←0.
  - Shifts DEVICE_CONFIG_WIDTH bits on channel 1.
  - Captures DEVICE_CONFIG_WIDTH `sdo1` samples into `rx_data`, zero-extended.
- READ_RESULT:
  - `sdi1` is held at 0.
  - Shifts RESULT_DATA_WIDTH bits on channel 1.
  - Captures the result into `rx_data`.
  - `dev_reset_n` is unchanged. Asserting `cs1_n` low forces a still-running device to report an all-zero result.
- RUN:
  - `dev_reset_n`←1.
  - No serial activity.
  - `done` pulses the cycle after accept.
- Bit i (N bits total):
  - SHIFT_LOW: SCK low for SCK_HALF cycles, MOSI = bit i.
  - `sdo1` is sampled in the last cycle of SHIFT_LOW.
  - SHIFT_HIGH: SCK high for SCK_HALF cycles.
  - MOSI advances on each SCK falling edge.
- After bit N-1: HOLD keeps SCK low and CS low for SCK_HALF cycles, then FINISH.
- FINISH: CS high, `busy`=0, `done`=1, `rx_data` updated, all in the same cycle.
- Only the channel addressed by `op` toggles; the other channel stays at idle values (SCK 0, MOSI 0, CS 1).
- Bit and phase counters are sized `$clog2(max width + 1)` and `$clog2(SCK_HALF + 1)`; there is no wrap within a transaction.

## Timing
- `start` sampled in cycle 0.
- Cycle 1: CS low, MOSI = MSB, `busy`=1.
- CS low for 2·N·SCK_HALF + SCK_HALF cycles.
- `done` at cycle 1 + 2·N·SCK_HALF + SCK_HALF.
- `start` while `busy`=1, including the `done` cycle, is ignored. A new command is accepted from the cycle after `done` at the earliest.
- Undefined `op` is impossible because all 4 codes are defined.
- Reset mid-transaction: all outputs return to reset values immediately, including CS high and `dev_reset_n`=0. A partial shift is discarded.
- `ready` is a status input only (see Configuration).

## Configuration
- `EXTERNAL_IO_HOST_AUTOREAD_EN` defined:
  - After RUN, the block stays `busy`=1 and does not pulse `done` for RUN.
  - It waits for `ready`, registered through a 2-flop synchroniser, to be 1.
  - It then performs READ_RESULT automatically and pulses `done` once at its end.
  - `start` is ignored while waiting.
- Undefined: RUN completes immediately and `ready` is unused.

## Test plan
- LOAD_JOB, JOB_CONFIG_WIDTH=8, `job_config`=0xA5, SCK_HALF=4 → eight `sck0` pulses; `sdi0` sampled at rising edges reads 1,0,1,0,0,1,0,1; `cs0_n` low 68 cycles; `done` at cycle 69; channel 1 idle.
- LOAD_DEVICE, width 4, `device_config`=0x9, model device holding 0x6 → `sdi1` sends 1001; `rx_data`=0x6, with the model's first-bit lag honoured per its sdo1 update rule; `dev_reset_n`=0.
- RUN then READ_RESULT, RESULT_DATA_WIDTH=16, model result 0xBEEF presented with MSB on `sdo1` before the first edge → `dev_reset_n`=1; `rx_data`=0xBEEF; `sdi1` all zeros.
- `start` pulsed at cycle 5 of a transaction and on the `done` cycle → both ignored; a `start` on the next cycle is accepted.
- `reset_n` low mid-shift after bit 3 → same cycle: CS high, SCK 0, `busy`=0, `dev_reset_n`=0, `rx_data`=0.
- With AUTOREAD_EN: RUN, `ready` rises 100 cycles later, model result 0x1234 → exactly one `done`; `rx_data`=0x1234; no `done` for RUN itself.
